// File: rtl/dec2bin_pkg.sv
// ============================================================================
// Module   : dec2bin_pkg
// Purpose  : Shared types, constants and width helper for the serial BCD
//            to binary converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec2bin_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SIGN_CODE = 4'hD;

  // Smallest width whose unsigned range covers 10^digits - 1, plus an
  // optional sign bit.
  function automatic int min_bin_w(input int digits, input bit signed_en);
    longint unsigned max_val;
    int              w;
    max_val = 64'd1;
    for (int i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    w = 1;
    for (int i = 1; i < 64; i++) begin
      if ((64'd1 << i) <= max_val) begin
        w = i + 1;
      end
    end
    return signed_en ? w + 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec2bin_digit_mac.sv
// ============================================================================
// Module   : dec2bin_digit_mac
// Purpose  : Combinational acc*10 + digit step; non-decimal codes add zero
//            and are flagged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec2bin_digit_mac
  import dec2bin_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] sum,
  output logic             illegal
);

  logic [BIN_W-1:0] digit_ext;

  always_comb begin
    illegal   = (digit > BCD_MAX);
    digit_ext = illegal ? '0 : BIN_W'(digit);
    sum       = (acc << 3) + (acc << 1) + digit_ext;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_to_binary.sv
// ============================================================================
// Module   : bcd_serial_to_binary
// Purpose  : Accepts BCD digits MSD-first over a valid/ready handshake and
//            emits the binary value of up to NUM_DIGITS digits.
// Config   : define BCD2BIN_SIGN_EN to treat a leading 4'hD as a minus sign.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_to_binary
  import dec2bin_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_binary,
  output logic             out_error
);

`ifdef BCD2BIN_SIGN_EN
  localparam bit SIGN_FEAT = 1'b1;
`else
  localparam bit SIGN_FEAT = 1'b0;
`endif

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  generate
    if (NUM_DIGITS < 1 || BIN_W < min_bin_w(NUM_DIGITS, SIGN_FEAT)) begin : g_width_check
      $error("bcd_serial_to_binary: BIN_W too narrow for NUM_DIGITS");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [BIN_W-1:0] mac_sum;
  logic             mac_illegal;
  logic             accept;
  logic             sign_hit;
  logic [BIN_W-1:0] final_val;

`ifdef BCD2BIN_SIGN_EN
  logic neg_q, neg_d;
`endif

  dec2bin_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc     (acc_q),
    .digit   (in_digit),
    .sum     (mac_sum),
    .illegal (mac_illegal)
  );

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign out_binary = acc_q;
  assign out_error  = err_q;
  assign accept     = in_valid && in_ready;

`ifdef BCD2BIN_SIGN_EN
  // Only the very first nibble of a number may be a sign.
  assign sign_hit  = (in_digit == SIGN_CODE) && (cnt_q == '0) && !neg_q;
  assign final_val = neg_q ? ('0 - mac_sum) : mac_sum;
`else
  assign sign_hit  = 1'b0;
  assign final_val = mac_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef BCD2BIN_SIGN_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (sign_hit) begin
`ifdef BCD2BIN_SIGN_EN
            neg_d = 1'b1;
`endif
            if (in_last) begin
              state_d = DONE;
            end
          end else begin
            acc_d = mac_sum;
            err_d = err_q | mac_illegal;
            cnt_d = cnt_q + 1'b1;
            // Auto-terminate once the digit budget is used up.
            if (in_last || (cnt_d == CNT_W'(NUM_DIGITS))) begin
              state_d = DONE;
              acc_d   = final_val;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef BCD2BIN_SIGN_EN
          neg_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

`default_nettype wire
